// File: rtl/execute_pipe_if.sv
// EX-stage bus for execute_pipe: operand/control inputs from ID/EX and the
// registered EX/MEM outputs, plus the FSM state for observation.
interface execute_pipe_if #(
    parameter int N = 64
);
    // valid_E qualifies every EX input in the same cycle; busy_E asks upstream
    // to hold ID/EX; valid_M qualifies the EX/MEM data outputs.
    logic         valid_E;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic         MulOp;
    logic [1:0]   ForwardA;
    logic [1:0]   ForwardB;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic [N-1:0] writeData_W;
    logic         stall_in;
    logic         flush;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;
    logic         valid_M;
    logic         busy_E;
    logic [1:0]   state_dbg;

    modport master (
        output valid_E, AluSrc, AluControl, MulOp, ForwardA, ForwardB,
               PC_E, signImm_E, readData1_E, readData2_E, writeData_W,
               stall_in, flush,
        input  PCBranch_M, aluResult_M, writeData_M, zero_M, valid_M,
               busy_E, state_dbg
    );

    modport slave (
        input  valid_E, AluSrc, AluControl, MulOp, ForwardA, ForwardB,
               PC_E, signImm_E, readData1_E, readData2_E, writeData_W,
               stall_in, flush,
        output PCBranch_M, aluResult_M, writeData_M, zero_M, valid_M,
               busy_E, state_dbg
    );
endinterface

// File: rtl/execute_pipe.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch target adder and
// a multi-cycle shift-add unsigned multiplier feeding the EX/MEM register.
module execute_pipe #(
    parameter int N = 64
) (
    input logic           clk,
    input logic           reset,
    execute_pipe_if.slave ex
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(N + 1);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  w_src_a;
    logic [N-1:0]  w_src_b;
    logic [N-1:0]  w_op_b;
    logic [N-1:0]  w_alu;
    logic [N-1:0]  w_pc_branch;
    logic          w_launch_mul;
    logic          w_last_step;

    logic [N-1:0]  r_mul_a;
    logic [N-1:0]  r_mul_b;
    logic [N-1:0]  r_prod;
    logic [N-1:0]  r_pc;
    logic [N-1:0]  r_imm;
    logic [N-1:0]  r_wd;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  r_alu_result_m;
    logic [N-1:0]  r_pc_branch_m;
    logic [N-1:0]  r_write_data_m;
    logic          r_zero_m;
    logic          r_valid_m;

    // Forward select 2'b10 takes this stage's own registered result.
    always_comb begin
        w_src_a = ex.readData1_E;
        w_src_b = ex.readData2_E;
        case (ex.ForwardA)
            2'b01:   w_src_a = ex.writeData_W;
            2'b10:   w_src_a = r_alu_result_m;
            default: w_src_a = ex.readData1_E;
        endcase
        case (ex.ForwardB)
            2'b01:   w_src_b = ex.writeData_W;
            2'b10:   w_src_b = r_alu_result_m;
            default: w_src_b = ex.readData2_E;
        endcase
    end

    assign w_op_b      = ex.AluSrc ? ex.signImm_E : w_src_b;
    assign w_pc_branch = ex.PC_E + (ex.signImm_E << 2);

    always_comb begin
        w_alu = '0;
        case (ex.AluControl)
            4'b0000: w_alu = w_src_a & w_op_b;
            4'b0001: w_alu = w_src_a | w_op_b;
            4'b0010: w_alu = w_src_a + w_op_b;
            4'b0110: w_alu = w_src_a - w_op_b;
            4'b0111: w_alu = w_op_b;
            4'b1100: w_alu = ~(w_src_a | w_op_b);
            default: w_alu = '0;
        endcase
    end

    assign w_launch_mul = (r_state == S_IDLE) && ex.valid_E && ex.MulOp;
    assign w_last_step  = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (ex.flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_launch_mul && !ex.stall_in) w_next = S_MUL;
                S_MUL:   if (w_last_step) w_next = S_DONE;
                S_DONE:  if (!ex.stall_in) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_prod         <= '0;
            r_pc           <= '0;
            r_imm          <= '0;
            r_wd           <= '0;
            r_cnt          <= '0;
            r_alu_result_m <= '0;
            r_pc_branch_m  <= '0;
            r_write_data_m <= '0;
            r_zero_m       <= 1'b0;
            r_valid_m      <= 1'b0;
        end else begin
            // Multiplier steps regardless of stall; only the low N bits are kept.
            if (r_state == S_MUL) begin
                if (r_mul_b[0]) r_prod <= r_prod + r_mul_a;
                r_mul_a <= r_mul_a << 1;
                r_mul_b <= r_mul_b >> 1;
                r_cnt   <= r_cnt + CW'(1);
            end
            if (ex.flush) begin
                r_valid_m <= 1'b0;
            end else if (!ex.stall_in) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_launch_mul) begin
                            r_mul_a   <= w_src_a;
                            r_mul_b   <= w_op_b;
                            r_wd      <= w_src_b;
                            r_pc      <= ex.PC_E;
                            r_imm     <= ex.signImm_E;
                            r_prod    <= '0;
                            r_cnt     <= '0;
                            r_valid_m <= 1'b0;
                        end else begin
                            r_alu_result_m <= w_alu;
                            r_zero_m       <= (w_alu == '0);
                            r_pc_branch_m  <= w_pc_branch;
                            r_write_data_m <= w_src_b;
                            r_valid_m      <= ex.valid_E;
                        end
                    end
                    S_DONE: begin
                        r_alu_result_m <= r_prod;
                        r_zero_m       <= (r_prod == '0);
                        r_pc_branch_m  <= r_pc + (r_imm << 2);
                        r_write_data_m <= r_wd;
                        r_valid_m      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ex.aluResult_M = r_alu_result_m;
    assign ex.PCBranch_M  = r_pc_branch_m;
    assign ex.writeData_M = r_write_data_m;
    assign ex.zero_M      = r_zero_m;
    assign ex.valid_M     = r_valid_m;
    assign ex.busy_E      = ex.stall_in || (r_state == S_MUL) || (w_launch_mul && !ex.flush);
    assign ex.state_dbg   = r_state;
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_execute_pipe;
    localparam int N = 64;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_pipe_if #(.N(N)) bus ();
    execute_pipe #(.N(N)) dut (.clk(clk), .reset(reset), .ex(bus.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic run_cmp = 1'b0;

    // Reference model state
    logic [N-1:0] exp_q[$];
    logic         m_valid = 1'b0;
    logic         m_known = 1'b0;
    logic         m_zero = 1'b0;
    logic [N-1:0] m_alu = '0;
    logic [N-1:0] m_pcb = '0;
    logic [N-1:0] m_wd = '0;
    logic [N-1:0] m_pend_pcb = '0;
    logic [N-1:0] m_pend_wd = '0;
    int           m_left = -1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] fwd(input logic [1:0] sel, input logic [N-1:0] rd,
                                         input logic [N-1:0] wb, input logic [N-1:0] mem);
        case (sel)
            2'b01:   return wb;
            2'b10:   return mem;
            default: return rd;
        endcase
    endfunction

    function automatic logic [N-1:0] alu_ref(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // Model: m_left counts multiply edges still to go (-1 = no multiply in flight).
    always @(posedge clk) begin : model
        logic [N-1:0] a, b, ob;
        a  = fwd(bus.ForwardA, bus.readData1_E, bus.writeData_W, m_alu);
        b  = fwd(bus.ForwardB, bus.readData2_E, bus.writeData_W, m_alu);
        ob = bus.AluSrc ? bus.signImm_E : b;
        if (reset) begin
            m_valid = 0; m_known = 1; m_zero = 0;
            m_alu = '0; m_pcb = '0; m_wd = '0; m_left = -1;
            exp_q.delete();
        end else if (bus.flush) begin
            m_valid = 0; m_known = 0; m_left = -1;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_left == 0) begin
            if (!bus.stall_in && exp_q.size() > 0) begin
                m_alu = exp_q.pop_front();
                m_zero = (m_alu == '0);
                m_pcb = m_pend_pcb; m_wd = m_pend_wd;
                m_valid = 1; m_known = 1; m_left = -1;
            end
        end else if (bus.stall_in) begin
            // hold
        end else if (bus.valid_E && bus.MulOp) begin
            exp_q.push_back(a * ob);
            m_pend_pcb = bus.PC_E + bus.signImm_E * 4;
            m_pend_wd = b;
            m_valid = 0; m_known = 0; m_left = N;
        end else if (bus.valid_E) begin
            m_alu = alu_ref(bus.AluControl, a, ob);
            m_zero = (m_alu == '0);
            m_pcb = bus.PC_E + bus.signImm_E * 4;
            m_wd = b;
            m_valid = 1; m_known = 1;
        end else begin
            m_valid = 0; m_known = 0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cyc_valid_M", bus.valid_M, m_valid);
            check("cyc_busy_E", bus.busy_E,
                  bus.stall_in || (m_left > 0) ||
                  ((m_left < 0) && bus.valid_E && bus.MulOp && !bus.flush));
            if (m_valid || m_known) begin
                check("cyc_aluResult_M", bus.aluResult_M, m_alu);
                check("cyc_zero_M", bus.zero_M, m_zero);
                check("cyc_PCBranch_M", bus.PCBranch_M, m_pcb);
                check("cyc_writeData_M", bus.writeData_M, m_wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_E = 0; bus.MulOp = 0; bus.AluSrc = 0; bus.AluControl = 4'b0000;
        bus.ForwardA = 2'b00; bus.ForwardB = 2'b00;
        bus.PC_E = '0; bus.signImm_E = '0; bus.readData1_E = '0; bus.readData2_E = '0;
        bus.writeData_W = '0; bus.stall_in = 0; bus.flush = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic src, input logic mul,
                         input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                         input logic [N-1:0] imm, input logic [N-1:0] pc);
        bus.valid_E = 1; bus.MulOp = mul; bus.AluSrc = src; bus.AluControl = op;
        bus.ForwardA = 2'b00; bus.ForwardB = 2'b00;
        bus.readData1_E = rd1; bus.readData2_E = rd2; bus.signImm_E = imm; bus.PC_E = pc;
    endtask

    logic [3:0]   t_op[7];
    logic [N-1:0] t_a[7];
    logic [N-1:0] t_b[7];
    logic [N-1:0] t_exp[7];

    initial begin
        int busy_cnt, edges, stray;
        logic got;
        t_op[0] = 4'b0000; t_a[0] = 64'hF0F0; t_b[0] = 64'h0FF0; t_exp[0] = 64'h00F0;
        t_op[1] = 4'b0001; t_a[1] = 64'hF0F0; t_b[1] = 64'h0FF0; t_exp[1] = 64'hFFF0;
        t_op[2] = 4'b0111; t_a[2] = 64'hF0F0; t_b[2] = 64'h0FF0; t_exp[2] = 64'h0FF0;
        t_op[3] = 4'b1100; t_a[3] = 64'hF0F0; t_b[3] = 64'h0FF0; t_exp[3] = 64'hFFFF_FFFF_FFFF_000F;
        t_op[4] = 4'b0011; t_a[4] = 64'hF0F0; t_b[4] = 64'h0FF0; t_exp[4] = 64'h0;
        t_op[5] = 4'b0110; t_a[5] = 64'h0;    t_b[5] = 64'h1;    t_exp[5] = ALL1;
        t_op[6] = 4'b0010; t_a[6] = ALL1;     t_b[6] = 64'h1;    t_exp[6] = 64'h0;

        idle_inputs();
        reset = 1;
        repeat (2) tick();
        run_cmp = 1;
        check("rst_aluResult_M", bus.aluResult_M, 0);
        check("rst_PCBranch_M", bus.PCBranch_M, 0);
        check("rst_writeData_M", bus.writeData_M, 0);
        check("rst_zero_M", bus.zero_M, 0);
        check("rst_valid_M", bus.valid_M, 0);
        check("rst_busy_E", bus.busy_E, 0);
        reset = 0;

        // ADD 5+7
        drive(4'b0010, 0, 0, 5, 7, 0, 0);
        tick();
        check("add_alu", bus.aluResult_M, 12);
        check("add_zero", bus.zero_M, 0);
        check("add_valid", bus.valid_M, 1);
        check("add_wd", bus.writeData_M, 7);

        // Forwarding: A from EX/MEM (12), B from WB (3)
        drive(4'b0010, 0, 0, 0, 99, 0, 0);
        bus.ForwardA = 2'b10; bus.ForwardB = 2'b01; bus.writeData_W = 3;
        tick();
        check("fwd_alu", bus.aluResult_M, 15);
        check("fwd_wd", bus.writeData_M, 3);
        bus.writeData_W = 0;

        // SUB 9-9 with immediate, branch target
        drive(4'b0110, 1, 0, 9, 0, 9, 64'h100);
        tick();
        check("sub_alu", bus.aluResult_M, 0);
        check("sub_zero", bus.zero_M, 1);
        check("sub_pcb", bus.PCBranch_M, 64'h124);

        // Remaining ALU ops and wrap-around; negative immediate branch offset
        for (int i = 0; i < 7; i++) begin
            drive(t_op[i], 0, 0, t_a[i], t_b[i], ALL1, 64'h1000);
            tick();
            check("tbl_alu", bus.aluResult_M, t_exp[i]);
            check("tbl_zero", bus.zero_M, (t_exp[i] == '0));
            check("tbl_pcb", bus.PCBranch_M, 64'h0FFC);
        end

        // Stall in IDLE holds EX/MEM
        drive(4'b0010, 0, 0, 5, 7, 0, 0);
        tick();
        drive(4'b0010, 0, 0, 1, 1, 0, 0);
        bus.stall_in = 1;
        #1;
        check("stall_idle_busy", bus.busy_E, 1);
        repeat (2) begin
            tick();
            check("stall_idle_alu", bus.aluResult_M, 12);
            check("stall_idle_valid", bus.valid_M, 1);
        end
        bus.stall_in = 0;
        tick();
        check("stall_idle_release", bus.aluResult_M, 2);

        // Multiply all-ones * 2
        drive(4'b0010, 0, 1, ALL1, 2, 1, 64'h40);
        busy_cnt = 0; edges = 0; got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.busy_E) busy_cnt++;
            tick();
            edges++;
            if (i == 0) idle_inputs();
            if (bus.valid_M) got = 1;
        end
        check("mul_seen", got, 1);
        check("mul_busy_cycles", busy_cnt, 65);
        check("mul_latency", edges, 66);
        check("mul_alu", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mul_pcb", bus.PCBranch_M, 64'h44);
        check("mul_wd", bus.writeData_M, 2);
        check("mul_zero", bus.zero_M, 0);

        // Flush on an IDLE multiply request: not launched, busy not raised
        drive(4'b0010, 0, 1, 3, 3, 0, 0);
        bus.flush = 1;
        #1;
        check("flush_idle_busy", bus.busy_E, 0);
        tick();
        idle_inputs();
        check("flush_idle_valid", bus.valid_M, 0);

        // Flush at multiply step 10, then an ADD
        drive(4'b0010, 0, 1, 3, 5, 0, 0);
        tick();
        idle_inputs();
        repeat (9) tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        check("flush_mul_valid", bus.valid_M, 0);
        drive(4'b0010, 0, 0, 1, 2, 0, 0);
        tick();
        check("flush_add_alu", bus.aluResult_M, 3);
        check("flush_add_valid", bus.valid_M, 1);
        idle_inputs();
        stray = 0;
        repeat (80) begin
            tick();
            if (bus.valid_M) stray++;
        end
        check("flush_no_stray", stray, 0);

        // Stall for 3 cycles while the multiply result waits
        drive(4'b0010, 0, 1, 6, 7, 4, 64'h200);
        tick();
        idle_inputs();
        repeat (64) tick();
        bus.stall_in = 1;
        repeat (3) begin
            #1;
            check("stall_done_busy", bus.busy_E, 1);
            tick();
            check("stall_done_valid", bus.valid_M, 0);
        end
        bus.stall_in = 0;
        tick();
        check("stall_done_alu", bus.aluResult_M, 42);
        check("stall_done_valid_rise", bus.valid_M, 1);
        check("stall_done_pcb", bus.PCBranch_M, 64'h210);
        check("stall_done_wd", bus.writeData_M, 7);

        // Reset in the middle of a multiply
        drive(4'b0010, 0, 1, 3, 3, 0, 64'h80);
        tick();
        idle_inputs();
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        check("rstmul_alu", bus.aluResult_M, 0);
        check("rstmul_pcb", bus.PCBranch_M, 0);
        check("rstmul_wd", bus.writeData_M, 0);
        check("rstmul_zero", bus.zero_M, 0);
        check("rstmul_valid", bus.valid_M, 0);
        check("rstmul_busy", bus.busy_E, 0);
        bus.stall_in = 1;
        #1;
        check("rstmul_busy_stall", bus.busy_E, 1);
        bus.stall_in = 0;
        stray = 0;
        repeat (70) begin
            tick();
            if (bus.valid_M) stray++;
        end
        check("rstmul_no_stray", stray, 0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
